mastermind_scorer: RTL and testbench
====================================

Name: mastermind_scorer

Overview:
- Scores one submitted guess row against the secret code for the game-state FSM in the top-level game module.
- Reads secret and guess pins from BOARD_RAM through a dedicated read port.
- Counts exact matches ("hits") and colour-only matches ("partials").
- Writes both counts back to BOARD_RAM as the row's hint cells. The VGA renderer draws them on its next frame.

Parameters:
- MAX_PINS, 16: upper bound on pins per row; pins_count is clamped to this.
- MAX_COLORS, 16: number of per-colour counter pairs; must be a power of 2.
- COLOR_W, 4: log2(MAX_COLORS); a pin colour is q[COLOR_W-1:0].
- ADDR_W, 12: BOARD_RAM address width.
- DATA_W, 8: BOARD_RAM data width.

Ports:
- CLK, in, 1: CLK_PLL domain clock.
- RST, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle request; sampled only in IDLE.
- pins_count, in, 8: pins per row (GS.options.pins_count); latched at start.
- secret_base, in, ADDR_W: RAM address of secret pin 0; latched at start.
- guess_base, in, ADDR_W: RAM address of guess pin 0; latched at start.
- hint_base, in, ADDR_W: hits written here, partials at hint_base+1; latched at start.
- ram_raddr, out, ADDR_W: BOARD_RAM read address.
- ram_q, in, DATA_W: BOARD_RAM read data; registered, valid 1 cycle after ram_raddr.
- ram_waddr, out, ADDR_W: BOARD_RAM write address.
- ram_wdata, out, DATA_W: BOARD_RAM write data.
- ram_wen, out, 1: BOARD_RAM write enable.
- busy, out, 1: high from the cycle after start is accepted through the DONE cycle.
- done, out, 1: one-cycle pulse when the result is valid.
- hits, out, 8: exact-match count; held until the next accepted start.
- partials, out, 8: colour-only match count; held until the next accepted start.
- win, out, 1: hits == latched pin count; held with hits.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- States: IDLE, RD_SEC, RD_GSS, CMP, SUM, WR_HITS, WR_PART, DONE.

Start handling:
- IDLE accepts a start pulse: latch inputs, n = min(pins_count, MAX_PINS).
- On the same edge: clear hits, partials, win, the pin index i, the colour index c, and all sec_cnt[] / gss_cnt[] counters.
- Next state: RD_SEC if n > 0, otherwise SUM.
- start outside IDLE is ignored; no queueing.

Per-pin loop (3 cycles per pin):
- RD_SEC: ram_raddr = secret_base + i.
- RD_GSS: latch s = ram_q[COLOR_W-1:0]; ram_raddr = guess_base + i.
- CMP: g = ram_q[COLOR_W-1:0].
  - If s == g: hits++.
  - Otherwise: sec_cnt[s]++ and gss_cnt[g]++.
  - Then i++. If i == n-1 go to SUM, else go to RD_SEC.
- Address addition wraps modulo 2^ADDR_W.
- ram_raddr holds its last value in all other states.

Counters and summation:
- sec_cnt and gss_cnt are 5 bits wide and cannot overflow for n <= MAX_PINS.
- SUM runs MAX_COLORS cycles: partials += min(sec_cnt[c], gss_cnt[c]); c++.
- Leave SUM after c == MAX_COLORS-1.

Write-back:
- WR_HITS: ram_wen = 1, ram_waddr = hint_base, ram_wdata = hits.
- WR_PART: ram_wen = 1, ram_waddr = hint_base + 1, ram_wdata = partials; win = (hits == n).
- DONE: done = 1, then IDLE.
- ram_wen is 0 in every other state.

Timing and invariants:
- Latency: with start accepted at edge k, done is high in cycle k + 3n + MAX_COLORS + 3.
- Invariant: hits + partials <= n.
- n == 0: hits = 0, partials = 0, win = 1 (degenerate; the game never issues it).
- Colour values >= MAX_COLORS alias through the low COLOR_W bits. Upstream guarantees pin_colors <= MAX_COLORS.

Integration and reset:
- The top-level game FSM must not drive its own BOARD_RAM writes while busy. The top level muxes the write port on busy.
- RST mid-operation:
  - Returns to IDLE immediately with all outputs 0.
  - No further RAM writes occur.
  - A hint cell already written stays written.

Test Plan:
- Exact win: MAX_COLORS=16, n=4, secret 1,2,3,4, guess 1,2,3,4, start at edge k -> done in cycle k+31; hits=4, partials=0, win=1; RAM[hint_base]=4, RAM[hint_base+1]=0.
- Full permutation: secret 1,1,2,2, guess 2,2,1,1 -> hits=0, partials=4, win=0.
- Mixed with duplicates: secret 1,2,3,4, guess 1,3,5,3 -> hits=1, partials=1. The duplicate 3 counts once.
- Busy and clamp: second start pulse during RD_GSS -> ignored; exactly one done pulse and exactly two ram_wen cycles. pins_count=20 -> treated as n=16; done at k+67.
- n=0 -> done at k+MAX_COLORS+3 = k+19; hits=0, partials=0, win=1; hint cells written with 0.
- Reset mid-SUM: assert RST asynchronously (not clock-aligned) -> busy, done and ram_wen go 0 at once; no write to hint_base. A subsequent start runs cleanly with correct counts, proving the counters were cleared.

Source files
------------

// File: rtl/mastermind_scorer.sv
// mastermind_scorer: scores one guess row against the secret code held in
// BOARD_RAM, then writes the hit / partial counts back as the row's hint
// cells. The work is serial: 3 cycles per pin, then one pass over the
// per-colour counters, then two RAM writes.
module mastermind_scorer #(
  parameter int MAX_PINS   = 16,
  parameter int MAX_COLORS = 16,
  parameter int COLOR_W    = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        pins_count,
  input  logic [ADDR_W-1:0] secret_base,
  input  logic [ADDR_W-1:0] guess_base,
  input  logic [ADDR_W-1:0] hint_base,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wen,
  output logic              busy,
  output logic              done,
  output logic [7:0]        hits,
  output logic [7:0]        partials,
  output logic              win
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_SEC  = 3'd1;
  localparam logic [2:0] RD_GSS  = 3'd2;
  localparam logic [2:0] CMP     = 3'd3;
  localparam logic [2:0] SUM     = 3'd4;
  localparam logic [2:0] WR_HITS = 3'd5;
  localparam logic [2:0] WR_PART = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  localparam logic [7:0]         PIN_LIM = 8'(MAX_PINS);
  localparam logic [COLOR_W-1:0] C_LAST  = COLOR_W'(MAX_COLORS - 1);

  logic [2:0]         state;
  logic [7:0]         n;
  logic [7:0]         i;
  logic [COLOR_W-1:0] c;
  logic [COLOR_W-1:0] s;
  logic [ADDR_W-1:0]  sec_b, gss_b, hint_b;
  logic [ADDR_W-1:0]  raddr_hold;
  // Unmatched-pin histograms; 5 bits cover a full row of one colour.
  logic [MAX_COLORS-1:0][4:0] sec_cnt;
  logic [MAX_COLORS-1:0][4:0] gss_cnt;

  logic [COLOR_W-1:0] g;
  logic [4:0]         cmin;

  assign g    = ram_q[COLOR_W-1:0];
  assign cmin = (sec_cnt[c] < gss_cnt[c]) ? sec_cnt[c] : gss_cnt[c];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // RAM port drive: read address is live in the read states and otherwise
  // holds the last address issued; writes only in the two hint states.
  always_comb begin
    ram_raddr = raddr_hold;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_wen   = 1'b0;
    case (state)
      RD_SEC:  ram_raddr = sec_b + ADDR_W'(i);
      RD_GSS:  ram_raddr = gss_b + ADDR_W'(i);
      WR_HITS: begin
        ram_wen   = 1'b1;
        ram_waddr = hint_b;
        ram_wdata = DATA_W'(hits);
      end
      WR_PART: begin
        ram_wen   = 1'b1;
        ram_waddr = hint_b + ADDR_W'(1);
        ram_wdata = DATA_W'(partials);
      end
      default: ;
    endcase
  end

  // Remember the last read address so it stays stable outside the read states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) raddr_hold <= '0;
    else     raddr_hold <= ram_raddr;
  end

  // Control FSM plus all datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      n        <= '0;
      i        <= '0;
      c        <= '0;
      s        <= '0;
      sec_b    <= '0;
      gss_b    <= '0;
      hint_b   <= '0;
      sec_cnt  <= '0;
      gss_cnt  <= '0;
      hits     <= '0;
      partials <= '0;
      win      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n        <= (pins_count > PIN_LIM) ? PIN_LIM : pins_count;
          sec_b    <= secret_base;
          gss_b    <= guess_base;
          hint_b   <= hint_base;
          i        <= '0;
          c        <= '0;
          sec_cnt  <= '0;
          gss_cnt  <= '0;
          hits     <= '0;
          partials <= '0;
          win      <= 1'b0;
          state    <= (pins_count != 8'd0) ? RD_SEC : SUM;
        end
        RD_SEC: state <= RD_GSS;
        RD_GSS: begin
          s     <= ram_q[COLOR_W-1:0];
          state <= CMP;
        end
        CMP: begin
          if (s == g) hits <= hits + 8'd1;
          else begin
            sec_cnt[s] <= sec_cnt[s] + 5'd1;
            gss_cnt[g] <= gss_cnt[g] + 5'd1;
          end
          i     <= i + 8'd1;
          state <= (i == n - 8'd1) ? SUM : RD_SEC;
        end
        // Colour-only matches: per colour, the smaller unmatched count pairs up.
        SUM: begin
          partials <= partials + {3'b000, cmin};
          c        <= c + COLOR_W'(1);
          if (c == C_LAST) state <= WR_HITS;
        end
        WR_HITS: state <= WR_PART;
        WR_PART: begin
          win   <= (hits == n);
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer: behavioural BOARD_RAM, directed rows with
// hand-computed results, and a scoreboard monitor that checks each done.
module tb_mastermind_scorer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pins_count = '0;
  logic [11:0] secret_base = '0, guess_base = '0, hint_base = '0;
  logic [11:0] ram_raddr, ram_waddr;
  logic [7:0]  ram_q = '0, ram_wdata;
  logic        ram_wen, busy, done, win;
  logic [7:0]  hits, partials;

  mastermind_scorer dut (
    .CLK(CLK), .RST(RST), .start(start), .pins_count(pins_count),
    .secret_base(secret_base), .guess_base(guess_base), .hint_base(hint_base),
    .ram_raddr(ram_raddr), .ram_q(ram_q), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_wen(ram_wen), .busy(busy), .done(done),
    .hits(hits), .partials(partials), .win(win)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:4095];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Registered-read RAM, one write port.
  always @(posedge CLK) begin
    ram_q <= mem[ram_raddr];
    if (ram_wen) mem[ram_waddr] = ram_wdata;
    cyc <= cyc + 1;
  end

  typedef struct {
    logic [7:0]  h;
    logic [7:0]  p;
    logic        w;
    int          lat;
    logic [11:0] hint;
    int          t0;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse is matched against the oldest
  // outstanding expectation.
  int  wen_cnt = 0;
  bit  prev_done = 0;
  always @(negedge CLK) begin
    if (RST) begin
      wen_cnt = 0;
      prev_done = 0;
    end else begin
      if (ram_wen) wen_cnt++;
      if (done) begin
        if (prev_done) chk("done_single_pulse", 1, 0);
        if (sbq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("hits", int'(hits), int'(e.h));
          chk("partials", int'(partials), int'(e.p));
          chk("win", int'(win), int'(e.w));
          chk("latency", cyc - e.t0 + 1, e.lat);
          chk("ram_hint_hits", int'(mem[e.hint]), int'(e.h));
          chk("ram_hint_part", int'(mem[e.hint + 12'd1]), int'(e.p));
          chk("wen_cycles", wen_cnt, 2);
        end
        wen_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic put4(input logic [11:0] b, input logic [7:0] a0, a1, a2, a3);
    mem[b] = a0;
    mem[b + 12'd1] = a1;
    mem[b + 12'd2] = a2;
    mem[b + 12'd3] = a3;
  endtask

  // Issue one scoring request and wait (bounded) for its done.
  task automatic run(input logic [7:0] pc, input logic [11:0] sb, gb, hb,
                     input logic [7:0] eh, ep, input logic ew, input bit poke);
    exp_t e;
    int   nn;
    int   guard;
    mem[hb] = 8'hEE;
    mem[hb + 12'd1] = 8'hEE;
    @(negedge CLK);
    pins_count = pc; secret_base = sb; guess_base = gb; hint_base = hb;
    start = 1'b1;
    nn = (pc > 8'd16) ? 16 : int'(pc);
    e.h = eh; e.p = ep; e.w = ew; e.hint = hb;
    e.lat = 3 * nn + 16 + 3;
    e.t0 = cyc + 1;
    sbq.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    if (poke) begin
      @(negedge CLK);
      chk("busy_during_run", int'(busy), 1);
      pins_count = 8'd1; secret_base = 12'h040; guess_base = 12'h0A0;
      hint_base = 12'h300;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
    end
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 0, 1);
      void'(sbq.pop_front());
    end
    @(negedge CLK);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wen", int'(ram_wen), 0);
    chk("rst_hits", int'(hits), 0);
    chk("rst_partials", int'(partials), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_raddr", int'(ram_raddr), 0);
    chk("rst_waddr", int'(ram_waddr), 0);
    RST = 1'b0;
    @(negedge CLK);

    put4(12'h040, 8'd1, 8'd2, 8'd3, 8'd4);
    put4(12'h050, 8'd1, 8'd2, 8'd3, 8'd4);
    put4(12'h070, 8'd1, 8'd1, 8'd2, 8'd2);
    put4(12'h080, 8'd2, 8'd2, 8'd1, 8'd1);
    put4(12'h0A0, 8'd1, 8'd2, 8'd3, 8'd4);
    put4(12'h0B0, 8'd1, 8'd3, 8'd5, 8'd3);
    for (int k = 0; k < 20; k++) begin
      mem[12'h100 + 12'(k)] = (k < 16) ? 8'(k) : 8'd5;
      mem[12'h200 + 12'(k)] = (k < 8) ? 8'(k) : ((k < 16) ? 8'(15 - k) : 8'd5);
    end
    // Secret row straddles the address wrap; colours alias via low bits.
    mem[12'hFFF] = 8'h11; mem[12'h000] = 8'h22;
    mem[12'h010] = 8'h01; mem[12'h011] = 8'h12;

    run(8'd4, 12'h040, 12'h050, 12'h060, 8'd4, 8'd0, 1'b1, 1'b0);   // exact win
    run(8'd4, 12'h070, 12'h080, 12'h090, 8'd0, 8'd4, 1'b0, 1'b0);   // permutation
    run(8'd4, 12'h0A0, 12'h0B0, 12'h0C0, 8'd1, 8'd1, 1'b0, 1'b0);   // duplicates
    run(8'd20, 12'h100, 12'h200, 12'h300, 8'd8, 8'd0, 1'b0, 1'b1);  // clamp + ignored start
    run(8'd0, 12'h040, 12'h050, 12'h0D0, 8'd0, 8'd0, 1'b1, 1'b0);   // n == 0
    run(8'd2, 12'hFFF, 12'h010, 12'h020, 8'd2, 8'd0, 1'b1, 1'b0);   // wrap + alias

    // Asynchronous reset in the middle of SUM
    mem[12'h0E0] = 8'hAA; mem[12'h0E1] = 8'hAA;
    @(negedge CLK);
    pins_count = 8'd4; secret_base = 12'h040; guess_base = 12'h050;
    hint_base = 12'h0E0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (17) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_wen", int'(ram_wen), 0);
    chk("arst_hits", int'(hits), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("arst_no_write_hits", int'(mem[12'h0E0]), 8'hAA);
    chk("arst_no_write_part", int'(mem[12'h0E1]), 8'hAA);

    run(8'd4, 12'h0A0, 12'h0B0, 12'h0F0, 8'd1, 8'd1, 1'b0, 1'b0);   // clean after reset

    chk("queue_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
